// File: rtl/parallel_to_serial_tx.sv
// -----------------------------------------------------------------------------
// parallel_to_serial_tx
//
// Purpose:
//   Takes a registered parallel word from the upstream register stage and
//   shifts it out LSB first. It advances one bit on each clock where shift_en
//   is high, so a slower serial link can pace the frame with a baud tick.
//   A valid/ready handshake loads the word. The block accepts a word only
//   while it is idle.
//
// Optional build macro:
//   PTS_PARITY_EN - when defined, the block adds one even-parity bit (the
//                   XOR of the loaded word) after bit W-1. The port list is
//                   the same in both builds.
//
// Parameters:
//   W            parallel word width in bits (>= 2)
//
// Ports:
//   clk          system clock; all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   data_in      parallel word from the upstream register stage
//   load_valid   upstream offers data_in this cycle
//   load_ready   block can accept a word (high only when idle)
//   shift_en     advance-one-bit enable
//   serial_out   current serial bit; 0 when serial_valid is low
//   serial_valid serial_out carries a frame bit
//   frame_start  high while bit 0 of the frame is presented
//   done         one-cycle pulse after the last bit of a frame
//
// All outputs are decoded from registered state only. There is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module parallel_to_serial_tx #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] data_in,
   input  logic         load_valid,
   output logic         load_ready,
   input  logic         shift_en,
   output logic         serial_out,
   output logic         serial_valid,
   output logic         frame_start,
   output logic         done
);

   // Bit counter width: clog2(W), never narrower than one bit.
   localparam int CW = ($clog2(W) < 1) ? 1 : $clog2(W);
   localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

`ifdef PTS_PARITY_EN
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_DONE   = 2'd2,
      S_PARITY = 2'd3
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_DONE   = 2'd2
   } state_t;
`endif

   state_t          state_q;
   logic [W-1:0]    shift_q;
   logic [CW-1:0]   cnt_q;
`ifdef PTS_PARITY_EN
   logic            parity_q;
`endif

   // -------------------------------------------------------------------------
   // Frame sequencer
   // -------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         cnt_q    <= '0;
`ifdef PTS_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (load_valid) begin
                  shift_q  <= data_in;
                  cnt_q    <= '0;
`ifdef PTS_PARITY_EN
                  parity_q <= ^data_in;
`endif
                  state_q  <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (shift_en) begin
                  // The last data bit leaves the register unshifted. Only
                  // the state changes, which keeps the final step cheap.
                  if (cnt_q == LAST_BIT) begin
`ifdef PTS_PARITY_EN
                     state_q <= S_PARITY;
`else
                     state_q <= S_DONE;
`endif
                  end else begin
                     shift_q <= shift_q >> 1;
                     cnt_q   <= cnt_q + 1'b1;
                  end
               end
            end

`ifdef PTS_PARITY_EN
            S_PARITY: begin
               if (shift_en) begin
                  state_q <= S_DONE;
               end
            end
`endif

            S_DONE: begin
               state_q <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   // -------------------------------------------------------------------------
   // Output decode (registered state only)
   // -------------------------------------------------------------------------
   logic in_shift;
   logic in_parity;

   assign in_shift = (state_q == S_SHIFT);
`ifdef PTS_PARITY_EN
   assign in_parity = (state_q == S_PARITY);
`else
   assign in_parity = 1'b0;
`endif

   assign load_ready   = (state_q == S_IDLE);
   assign done         = (state_q == S_DONE);
   assign serial_valid = in_shift | in_parity;
   assign frame_start  = in_shift & (cnt_q == '0);

`ifdef PTS_PARITY_EN
   assign serial_out = in_shift  ? shift_q[0] :
                       in_parity ? parity_q   : 1'b0;
`else
   assign serial_out = in_shift ? shift_q[0] : 1'b0;
`endif

endmodule
